keypad_scan_debounce: RTL and testbench



---
 rtl/keypad_scan_debounce.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: one-hot column drive, 2-flop row sync, press/release debounce.
// Define KEYPAD_LAST_TWO_EN to add the lastKeys two-digit history output.
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key,
  output logic       keyValid,
  output logic       keyHeld
`ifdef KEYPAD_LAST_TWO_EN
  ,
  output logic [7:0] lastKeys
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t           state_q, state_d;
  logic [3:0]       rows_meta_q, rows_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       row_first;
  logic [3:0]       columns_q, columns_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             row_hit;
`ifdef KEYPAD_LAST_TWO_EN
  logic [7:0]       last_q, last_d;
`endif

  // Lowest active row index wins when several rows are high.
  always_comb begin
    row_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows_s_q[i]) row_first = 2'(i);
    end
  end

  assign row_hit = rows_s_q[row_q];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    db_d    = db_q;
    col_d   = col_q;
    row_d   = row_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_LAST_TWO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (|rows_s_q) begin
            row_d   = row_first;
            db_d    = '0;
            state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PRESS_DB: begin
        if (!row_hit) begin
          col_d   = col_q + 2'd1;
          div_d   = '0;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          key_d   = {row_q, col_q};
          valid_d = 1'b1;
          held_d  = 1'b1;
          state_d = HELD;
`ifdef KEYPAD_LAST_TWO_EN
          last_d  = {last_q[3:0], row_q, col_q};
`endif
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!row_hit) begin
          db_d    = '0;
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        // A bounce back high restarts the release qualification from HELD.
        if (row_hit) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
    columns_d = 4'b0001 << col_d;
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      rows_meta_q <= '0;
      rows_s_q    <= '0;
      state_q     <= SCAN;
      div_q       <= '0;
      db_q        <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      columns_q   <= 4'b0001;
      key_q       <= 4'd0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
`ifdef KEYPAD_LAST_TWO_EN
      last_q      <= 8'd0;
`endif
    end else begin
      rows_meta_q <= rows;
      rows_s_q    <= rows_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      db_q        <= db_d;
      col_q       <= col_d;
      row_q       <= row_d;
      columns_q   <= columns_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
`ifdef KEYPAD_LAST_TWO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign columns  = columns_q;
  assign key      = key_q;
  assign keyValid = valid_q;
  assign keyHeld  = held_q;
`ifdef KEYPAD_LAST_TWO_EN
  assign lastKeys = last_q;
`endif

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: directed keypad presses, keyValid scoreboard.
// Keys are modelled as a 16-bit matrix shorting row r to column c (bit r*4+c).
module tb_keypad_scan_debounce;

  logic       ph1;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [3:0] key;
  logic       keyValid;
  logic       keyHeld;
`ifdef KEYPAD_LAST_TWO_EN
  logic [7:0] lastKeys;
`endif

  logic [15:0] keys_down;
  logic [3:0]  sb[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          valid_cnt = 0;
  int          exp_valid = 0;

  keypad_scan_debounce #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .ph1     (ph1),
    .reset   (reset),
    .rows    (rows),
    .columns (columns),
    .key     (key),
    .keyValid(keyValid),
    .keyHeld (keyHeld)
`ifdef KEYPAD_LAST_TWO_EN
    ,
    .lastKeys(lastKeys)
`endif
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  always_comb begin
    rows = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[r*4+c] && columns[c]) rows[r] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ph1);
    #1;
  endtask

  task automatic wait_cols(input logic [3:0] target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (columns !== target && n < budget);
    chk(name, 32'(columns), 32'(target));
  endtask

  task automatic wait_held(input logic target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (keyHeld !== target && n < budget);
    chk(name, 32'(keyHeld), 32'(target));
  endtask

  // Scoreboard monitor: every keyValid pulse must match the next queued key.
  always @(posedge ph1) begin
    logic [3:0] exp_key;
    #1;
    if (keyValid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_keyValid: got key %0h, want no pulse", key);
      end else begin
        exp_key = sb.pop_front();
        $display("keyValid key=%0h expected=%0h", key, exp_key);
        chk("sb_key", 32'(key), 32'(exp_key));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] colexp;
    one       = 4'b0001;
    reset     = 1'b1;
    keys_down = '0;
    repeat (3) @(posedge ph1);
    @(negedge ph1);
    reset = 1'b0;

    // Idle scan: each column driven for 4 cycles, wrapping back to column 0.
    chk("t1_col_reset", 32'(columns), 32'(4'b0001));
    chk("t1_held_reset", 32'(keyHeld), 0);
    chk("t1_key_reset", 32'(key), 0);
    for (int k = 1; k < 20; k++) begin
      tick(1);
      colexp = one << ((k / 4) % 4);
      chk("t1_scan", 32'(columns), 32'(colexp));
    end
    chk("t1_no_valid", 32'(valid_cnt), 0);

    // Row 2 on column 1 -> key 9; keyValid exactly 12 cycles after column 1 appears.
    sb.push_back(4'h9);
    exp_valid++;
    keys_down[9] = 1'b1;
    wait_cols(4'b0010, 20, "t2_reach_col1");
    tick(11);
    chk("t2_held_early", 32'(keyHeld), 0);
    tick(1);
    chk("t2_held_on", 32'(keyHeld), 1);
    chk("t2_key", 32'(key), 32'(4'h9));
    tick(27);
    chk("t2_col_frozen", 32'(columns), 32'(4'b0010));
    chk("t2_held_hold", 32'(keyHeld), 1);
    chk("t2_one_pulse", 32'(valid_cnt), 1);

    // Release with two bounces, then steady low: keyHeld falls 11 edges after final low.
    for (int i = 0; i < 8; i++) begin
      keys_down[9] = ((i / 2) % 2) == 1;
      tick(1);
      chk("t4_bounce_held", 32'(keyHeld), 1);
    end
    keys_down[9] = 1'b0;
    tick(10);
    chk("t4_held_before", 32'(keyHeld), 1);
    tick(1);
    chk("t4_held_fall", 32'(keyHeld), 0);
    chk("t4_col_resume", 32'(columns), 32'(4'b0100));

    // Short press aborted inside the press debounce window.
    wait_cols(4'b0001, 40, "t3_reach_col0");
    keys_down[9] = 1'b1;
    wait_cols(4'b0010, 20, "t3_reach_col1");
    tick(6);
    keys_down[9] = 1'b0;
    tick(2);
    chk("t3_col_frozen", 32'(columns), 32'(4'b0010));
    tick(1);
    chk("t3_col_resume", 32'(columns), 32'(4'b0100));
    tick(20);
    chk("t3_no_pulse", 32'(valid_cnt), 1);
    chk("t3_key_kept", 32'(key), 32'(4'h9));

    // Rows 1 and 3 together on column 3 -> row 1 wins, key 7.
    sb.push_back(4'h7);
    exp_valid++;
    keys_down[7]  = 1'b1;
    keys_down[15] = 1'b1;
    wait_held(1'b1, 80, "t5_held_on");
    chk("t5_key", 32'(key), 32'(4'h7));
    chk("t5_col_frozen", 32'(columns), 32'(4'b1000));
    keys_down[7]  = 1'b0;
    keys_down[15] = 1'b0;
    wait_held(1'b0, 40, "t5_held_off");

`ifdef KEYPAD_LAST_TWO_EN
    // History: key 2 then key E.
    sb.push_back(4'h2);
    exp_valid++;
    keys_down[2] = 1'b1;
    wait_held(1'b1, 80, "t6_held_2");
    keys_down[2] = 1'b0;
    wait_held(1'b0, 40, "t6_rel_2");
    sb.push_back(4'hE);
    exp_valid++;
    keys_down[14] = 1'b1;
    wait_held(1'b1, 80, "t6_held_e");
    keys_down[14] = 1'b0;
    wait_held(1'b0, 40, "t6_rel_e");
    chk("t6_lastkeys", 32'(lastKeys), 32'(8'h2E));
`endif

    // Reset during press debounce: outputs clear without a clock edge, no pulse later.
    keys_down[5] = 1'b1;
    wait_cols(4'b0010, 40, "t7_reach_col1");
    tick(6);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_col_async", 32'(columns), 32'(4'b0001));
    chk("t7_key_async", 32'(key), 0);
    chk("t7_held_async", 32'(keyHeld), 0);
    chk("t7_valid_async", 32'(keyValid), 0);
`ifdef KEYPAD_LAST_TWO_EN
    chk("t7_last_async", 32'(lastKeys), 0);
`endif
    keys_down = '0;
    @(negedge ph1);
    reset = 1'b0;
    tick(40);
    chk("t7_no_pulse", 32'(valid_cnt), 32'(exp_valid));
    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
